// File: rtl/palindrome_sched.sv
// Multi-requester scheduler that streams each granted word MSB-first into an external
// 3-bit palindrome detector and reports the hit count. Define PALSCHED_RR_EN for round-robin arbitration.
module palindrome_sched #(
  parameter int NREQ   = 4,
  parameter int WORD_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*WORD_W-1:0]   req_data_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic                     x_o,
  output logic                     det_reset_o,
  input  logic                     palindrome_i,
  output logic                     res_valid_o,
  output logic [2:0]               res_id_o,
  output logic [3:0]               res_count_o,
  input  logic                     res_ready_i
);

  localparam int BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [BC_W-1:0] FIRST_CMP_BIT = BC_W'(2);

  typedef enum logic [1:0] {IDLE, FLUSH, SHIFT, DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BC_W-1:0]     r_bitcnt;
  logic [3:0]          r_count;
  logic [2:0]          r_id;
  logic [WORD_W-1:0]   r_word;

  logic                w_gnt_vld;
  logic                w_gnt_fire;
  logic [2:0]          w_gnt_idx;
  logic [WORD_W-1:0]   w_gnt_word;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

`ifdef PALSCHED_RR_EN
  logic [2:0] r_ptr;

  // r_ptr holds the first index to try; it moves past each winner.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_word = '0;
    for (int o = 0; o < NREQ; o++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!w_gnt_vld && req_valid_i[k] && (k == (int'(r_ptr) + o) % NREQ)) begin
          w_gnt_vld  = 1'b1;
          w_gnt_idx  = 3'(k);
          w_gnt_word = req_data_i[k*WORD_W +: WORD_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_gnt_fire) begin
      r_ptr <= 3'((int'(w_gnt_idx) + 1) % NREQ);
    end
  end
`else
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_word = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        w_gnt_vld  = 1'b1;
        w_gnt_idx  = 3'(k);
        w_gnt_word = req_data_i[k*WORD_W +: WORD_W];
      end
    end
  end
`endif

  // A grant is only ever issued from IDLE, and never while reset is held.
  assign w_gnt_fire = !reset && (r_state == IDLE) && w_gnt_vld;

  always_comb begin
    req_ready_o = '0;
    if (w_gnt_fire) begin
      req_ready_o = NREQ'(1) << w_gnt_idx;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt_fire) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = SHIFT;
      SHIFT:   if (r_bitcnt == LAST_BIT) w_state_nxt = DONE;
      DONE:    if (res_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_count  <= '0;
      r_id     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_gnt_fire) begin
            r_id    <= w_gnt_idx;
            r_count <= '0;
          end
        end
        FLUSH: r_bitcnt <= '0;
        SHIFT: begin
          r_bitcnt <= r_bitcnt + 1'b1;
          // The detector window is only full from the third bit onwards.
          if ((r_bitcnt >= FIRST_CMP_BIT) && palindrome_i) begin
            r_count <= sat_inc(r_count);
          end
        end
        default: ;
      endcase
    end
  end

  // Word shifts left so the bit on the wire is always the MSB.
  always_ff @(posedge clk) begin
    if (w_gnt_fire) begin
      r_word <= w_gnt_word;
    end else if (r_state == SHIFT) begin
      r_word <= {r_word[WORD_W-2:0], 1'b0};
    end
  end

  assign x_o         = (r_state == SHIFT) && r_word[WORD_W-1];
  assign det_reset_o = reset || (r_state == FLUSH);
  assign res_valid_o = (r_state == DONE);
  assign res_id_o    = r_id;
  assign res_count_o = r_count;

endmodule

// File: tb/tb_palindrome_sched.sv
// Scoreboard bench for palindrome_sched: a behavioural detector and reference
// arbiter/counter predict every grant and result; a monitor compares them.
module tb_palindrome_sched;
  localparam int NREQ   = 4;
  localparam int WORD_W = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ*WORD_W-1:0] req_data_i;
  logic [NREQ-1:0]        req_ready_o;
  logic                   x_o, det_reset_o, palindrome_i;
  logic                   res_valid_o, res_ready_i;
  logic [2:0]             res_id_o;
  logic [3:0]             res_count_o;

  palindrome_sched #(.NREQ(NREQ), .WORD_W(WORD_W)) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .x_o(x_o), .det_reset_o(det_reset_o),
    .palindrome_i(palindrome_i), .res_valid_o(res_valid_o), .res_id_o(res_id_o),
    .res_count_o(res_count_o), .res_ready_i(res_ready_i)
  );

  always #5 clk = ~clk;

  // External detector: flags when the current bit equals the one two cycles back.
  logic [1:0] det_h;
  always @(posedge clk or posedge det_reset_o) begin
    if (det_reset_o) det_h <= 2'b00;
    else             det_h <= {det_h[0], x_o};
  end
  assign palindrome_i = (x_o == det_h[1]);

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: count of positions i where bit i equals bit i+2.
  function automatic int ref_count(input logic [WORD_W-1:0] w);
    int c = 0;
    for (int i = 0; i + 2 < WORD_W; i++) if (w[i] == w[i+2]) c++;
    return c;
  endfunction

  function automatic int ref_pick(input logic [NREQ-1:0] v, input int start);
    for (int o = 0; o < NREQ; o++) begin
      int k;
      k = (start + o) % NREQ;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  typedef struct packed { logic [2:0] id; logic [3:0] cnt; } exp_t;
  exp_t sbq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit         busy = 0;
  int         ref_ptr = 0;
  int         g_cyc = 0;
  bit         prev_rv = 0;
  bit         hold_vld = 0;
  logic [2:0] hold_id;
  logic [3:0] hold_cnt;
  int         ngrants = 0, naccepts = 0;
  int         last_gk = 0, last_id = -1, last_cnt = -1;

  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
      busy = 0; ref_ptr = 0; prev_rv = 0; hold_vld = 0;
    end else begin
      if (busy) begin
        chk("ready_while_busy", int'(req_ready_o), 0);
      end else if (req_valid_i != '0) begin
        int k;
`ifdef PALSCHED_RR_EN
        k = ref_pick(req_valid_i, ref_ptr);
        ref_ptr = (k + 1) % NREQ;
`else
        k = ref_pick(req_valid_i, 0);
`endif
        chk("grant", int'(req_ready_o), 1 << k);
        sbq.push_back('{id: 3'(k), cnt: 4'(ref_count(req_data_i[k*WORD_W +: WORD_W]))});
        busy = 1; g_cyc = cyc; last_gk = k; ngrants++;
      end else begin
        chk("no_grant_idle", int'(req_ready_o), 0);
      end

      if (res_valid_o && !prev_rv) chk("latency", cyc - g_cyc, WORD_W + 2);
      if (hold_vld) begin
        chk("hold_valid", int'(res_valid_o), 1);
        chk("hold_id", int'(res_id_o), int'(hold_id));
        chk("hold_count", int'(res_count_o), int'(hold_cnt));
      end
      if (res_valid_o && res_ready_i) begin
        if (sbq.size() == 0) begin
          chk("spurious_result", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("res_id", int'(res_id_o), int'(e.id));
          chk("res_count", int'(res_count_o), int'(e.cnt));
        end
        last_id = int'(res_id_o); last_cnt = int'(res_count_o);
        busy = 0; hold_vld = 0; naccepts++;
      end else if (res_valid_o) begin
        hold_vld = 1; hold_id = res_id_o; hold_cnt = res_count_o;
      end else begin
        hold_vld = 0;
      end
      prev_rv = res_valid_o;
    end
  end

  task automatic set_req(input int k, input bit v, input logic [WORD_W-1:0] w);
    req_valid_i[k] = v;
    req_data_i[k*WORD_W +: WORD_W] = w;
  endtask

  task automatic wait_grants(input int target, input int budget);
    int t = 0;
    while (ngrants < target && t < budget) begin @(posedge clk); #1; t++; end
    if (ngrants < target) chk("grant_timeout", ngrants, target);
  endtask

  task automatic wait_accepts(input int target, input int budget);
    int t = 0;
    while (naccepts < target && t < budget) begin @(posedge clk); #1; t++; end
    if (naccepts < target) chk("accept_timeout", naccepts, target);
  endtask

  task automatic run_one(input int k, input logic [WORD_W-1:0] w, input int expc);
    int g, a;
    g = ngrants; a = naccepts;
    set_req(k, 1'b1, w);
    wait_grants(g + 1, 30);
    set_req(k, 1'b0, WORD_W'($urandom));
    wait_accepts(a + 1, 40);
    chk("dir_id", last_id, k);
    chk("dir_count", last_cnt, expc);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", int'(req_ready_o), 0);
    chk("rst_x", int'(x_o), 0);
    chk("rst_det_reset", int'(det_reset_o), 1);
    chk("rst_res_valid", int'(res_valid_o), 0);
    chk("rst_res_id", int'(res_id_o), 0);
    chk("rst_res_count", int'(res_count_o), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int          dk[6] = '{0, 1, 2, 3, 1, 2};
  logic [7:0]  dw[6] = '{8'b10101010, 8'b00110011, 8'b11111111, 8'b10010110, 8'b00000000, 8'b01101001};
  int          dc[6] = '{6, 0, 6, 2, 6, 2};

  initial begin
    int lg, t, target, a0, g0;
    int seq[$];
    reset = 1'b1; req_valid_i = '1; res_ready_i = 1'b1;
    for (int k = 0; k < NREQ; k++) req_data_i[k*WORD_W +: WORD_W] = WORD_W'($urandom);
    #3 chk_reset_outputs();
    req_valid_i = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Directed words with known counts
    for (int i = 0; i < 6; i++) run_one(dk[i], dw[i], dc[i]);

    // Random contention and random result backpressure
    target = naccepts + 25; lg = ngrants; t = 0;
    while (naccepts < target && t < 3000) begin
      @(posedge clk); #1; t++;
      if (ngrants != lg) begin
        lg = ngrants;
        set_req(last_gk, 1'($urandom_range(0, 1)), WORD_W'($urandom));
      end
      for (int k = 0; k < NREQ; k++)
        if (!req_valid_i[k] && $urandom_range(0, 3) == 0) set_req(k, 1'b1, WORD_W'($urandom));
      res_ready_i = ($urandom_range(0, 3) != 0);
    end
    if (naccepts < target) chk("random_timeout", naccepts, target);
    req_valid_i = '0; res_ready_i = 1'b1;
    wait_accepts(ngrants, 40);

    // Held result: no grants and stable outputs while the consumer stalls
    res_ready_i = 1'b0;
    g0 = ngrants; a0 = naccepts;
    set_req(3, 1'b1, 8'b11111111);
    wait_grants(g0 + 1, 30);
    set_req(3, 1'b0, 8'h00);
    set_req(0, 1'b1, 8'b10010110);
    t = 0;
    while (!res_valid_o && t < 30) begin @(posedge clk); #1; t++; end
    chk("bp_valid_reached", int'(res_valid_o), 1);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_valid_held", int'(res_valid_o), 1);
    chk("bp_count_held", int'(res_count_o), 6);
    chk("bp_no_ready", int'(req_ready_o), 0);
    res_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_back_idle_valid", int'(res_valid_o), 0);
    chk("bp_back_idle_grant", int'(req_ready_o), 1);
    wait_grants(g0 + 2, 5);
    set_req(0, 1'b0, 8'h00);
    wait_accepts(a0 + 2, 40);
    chk("bp_second_count", last_cnt, 2);

    // All requesters held valid from a fresh reset
    pulse_reset();
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, WORD_W'($urandom));
    lg = ngrants; a0 = naccepts; t = 0;
    while (seq.size() < 5 && t < 200) begin
      @(posedge clk); #1; t++;
      if (ngrants != lg) begin lg = ngrants; set_req(last_gk, 1'b1, WORD_W'($urandom)); end
      if (naccepts != a0) begin a0 = naccepts; seq.push_back(last_id); end
    end
    req_valid_i = '0;
    chk("seq_len", seq.size(), 5);
    for (int i = 0; i < seq.size(); i++) begin
`ifdef PALSCHED_RR_EN
      chk("seq_id", seq[i], i % NREQ);
`else
      chk("seq_id", seq[i], 0);
`endif
    end
    repeat (15) @(posedge clk);
    #1;

    // Reset on the fourth SHIFT cycle discards the word
    g0 = ngrants;
    set_req(2, 1'b1, 8'b10010110);
    wait_grants(g0 + 1, 30);
    set_req(2, 1'b0, 8'h00);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_outputs();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    run_one(1, 8'b10101010, 6);

    chk("queue_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/palindrome_sched.md
PALINDROME_SCHED -- requirements
Module: palindrome_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter WORD_W, default 8: bits per word (3..16).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid_i  input  NREQ: per-requester word valid.
REQ-006 SHALL have port req_data_i  input  NREQ*WORD_W: packed words; requester k occupies bits [k*WORD_W +: WORD_W].
REQ-007 SHALL have port req_ready_o  output  NREQ: one-hot grant/accept strobe.
REQ-008 SHALL have port x_o  output  1: serial bit to the external 3-bit palindrome detector.
REQ-009 SHALL have port det_reset_o  output  1: reset to the detector.
REQ-010 SHALL have port palindrome_i  input  1: detector flag; high when the current x_o equals the bit sent two cycles earlier.
REQ-011 SHALL have port res_valid_o  output  1: result valid.
REQ-012 SHALL have port res_id_o  output  3: index of the requester that owns the result.
REQ-013 SHALL have port res_count_o  output  4: number of palindromic 3-bit windows in the word.
REQ-014 SHALL have port res_ready_i  input  1: result consumer ready.

Function
REQ-015 SHALL implement states IDLE, FLUSH, SHIFT, DONE.
REQ-016 In IDLE with any req_valid_i bit set, the block SHALL select one requester, assert its req_ready_o bit for exactly that cycle, latch its word and index, clear the count, and go to FLUSH.
REQ-017 req_ready_o SHALL be all-zero outside IDLE and whenever no requester is valid.
REQ-018 FLUSH SHALL last one cycle with det_reset_o=1 and x_o=0, then go to SHIFT with bit counter 0.
REQ-019 In SHIFT, x_o SHALL equal latched word bit [WORD_W-1-bitcnt] (MSB first), with one bit per cycle for WORD_W cycles.
REQ-020 At each SHIFT clock edge with bitcnt>=2 and palindrome_i=1, the count SHALL increment; palindrome_i SHALL be ignored for bitcnt 0 and 1.
REQ-021 After bit WORD_W-1 the block SHALL go to DONE; res_valid_o SHALL rise WORD_W+2 cycles after the grant cycle (10 for WORD_W=8).
REQ-022 In DONE, res_valid_o, res_id_o and res_count_o SHALL be held stable until res_valid_o && res_ready_i; the block then returns to IDLE.
REQ-023 No new grant SHALL occur in the cycle a result is accepted; at most one grant is issued per word.
REQ-024 res_count_o SHALL range 0..WORD_W-2 and never wrap.
REQ-025 res_valid_o SHALL be 0 in all states except DONE; x_o SHALL be 0 outside SHIFT.
REQ-026 A requester dropping req_valid_i after its grant SHALL NOT affect the word in flight.

Reset
REQ-027 Asserting reset SHALL immediately force IDLE, bitcnt=0, count=0, round-robin pointer=0, res_valid_o=0, req_ready_o=0, x_o=0, res_id_o=0 and res_count_o=0.
REQ-028 det_reset_o SHALL be 1 while reset is asserted.
REQ-029 Reset during SHIFT or DONE SHALL discard the word in flight with no result produced.

Configuration
REQ-030 With macro PALSCHED_RR_EN defined, arbitration SHALL be round-robin: search starts at last grant+1 modulo NREQ, and the pointer updates on each grant.
REQ-031 Without PALSCHED_RR_EN, arbitration SHALL be fixed priority, with the lowest valid index winning; the pointer logic SHALL be absent.

Verification
REQ-032 Word 8'b10101010 from requester 0 -> res_id_o=0, res_count_o=6, res_valid_o rising 10 cycles after the grant.
REQ-033 Words 8'b00110011 -> count 0; 8'b11111111 -> count 6; 8'b10010110 -> count 2.
REQ-034 With all four requesters held valid and res_ready_i=1: PALSCHED_RR_EN defined -> res_id_o sequence 0,1,2,3,0; undefined -> 0,0,0,0.
REQ-035 With res_ready_i=0 for 20 cycles in DONE -> res_valid_o and the outputs are stable, and req_ready_o stays 0; after res_ready_i=1 for one cycle -> IDLE.
REQ-036 Reset asserted on the 4th SHIFT cycle -> same-cycle outputs all at reset values; after release, a new request completes with the correct count.
